// File: rtl/uge_arb_pkg.sv
// Shared definitions for the time-shared unsigned compare/subtract arbiter.
//   N_DEF / W_DEF : default requester count and operand width
//   idw()         : requester-index width for a given requester count
//   oh2idx()      : one-hot vector (up to 32 bits) to bit index
package uge_arb_pkg;
  localparam int N_DEF = 4;
  localparam int W_DEF = 4;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Zero input maps to 0; callers only use the result when a bit is set.
  function automatic int oh2idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) if (oh[i]) idx = i;
    return idx;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req  : request vector
//   last : index granted most recently; search starts at last+1
//   en   : grant enable; gnt is all-zero when low
//   gnt  : one-hot grant, never set for a non-requesting bit
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  input  logic           en,
  output logic [N-1:0]   gnt
);
  logic [IDW:0]   sh;
  logic [N-1:0]   rot;
  logic [N-1:0]   g;
  logic [2*N-1:0] gdbl;
  logic           found;

  // Rotate so bit 0 is requester last+1, pick the lowest set bit, rotate back.
  assign sh  = {1'b0, last} + {{IDW{1'b0}}, 1'b1};
  assign rot = N'({req, req} >> sh);

  always_comb begin
    g     = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (rot[j] && !found) begin
        g[j]  = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign gdbl = {{N{1'b0}}, g} << sh;
  assign gnt  = en ? (gdbl[N-1:0] | gdbl[2*N-1:N]) : '0;
endmodule

// File: rtl/uge_share_arbiter.sv
// One W-bit unsigned compare/subtract unit shared by N requesters.
// Round-robin accept (one per cycle) into an issue stage, result registered
// in an output stage with a valid/ready response port.
//   CLK, RESETN          : clock, async active-low reset
//   REQ, REQ_A, REQ_B    : per-requester valid and operands (flattened i*W)
//   GNT                  : combinational one-hot accept
//   RSP_VALID/RSP_READY  : response handshake
//   RSP_ID/RSP_GE/RSP_DIFF : requester index, A>=B, (A-B) mod 2^W
module uge_share_arbiter
  import uge_arb_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int W   = W_DEF,
  parameter int IDW = idw(N)
) (
  input  logic           CLK,
  input  logic           RESETN,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] REQ_A,
  input  logic [N*W-1:0] REQ_B,
  output logic [N-1:0]   GNT,
  output logic           RSP_VALID,
  input  logic           RSP_READY,
  output logic [IDW-1:0] RSP_ID,
  output logic           RSP_GE,
  output logic [W-1:0]   RSP_DIFF
);
  logic [N-1:0][W-1:0] a_v, b_v;
  logic [2:1]          vld_pipe;
  logic [IDW-1:0]      last_q, id1, id2, gnt_idx;
  logic [W-1:0]        a1, b1, diff2;
  logic                ge2;
  logic                adv1, adv2;
  logic [W:0]          sum;

  assign a_v = REQ_A;
  assign b_v = REQ_B;

  assign adv2 = !vld_pipe[2] | RSP_READY;
  assign adv1 = !vld_pipe[1] | adv2;

  // Grants are suppressed while reset is held so nothing looks accepted.
  rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
    .req  (REQ),
    .last (last_q),
    .en   (adv1 & RESETN),
    .gnt  (GNT)
  );

  assign gnt_idx = IDW'(oh2idx(32'(GNT)));

  // A + ~B + 1: carry-out is the unsigned GE flag.
  assign sum = {1'b0, a1} + {1'b0, ~b1} + {{W{1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      vld_pipe <= '0;
      last_q   <= IDW'(N - 1);
      id1      <= '0;
      a1       <= '0;
      b1       <= '0;
      id2      <= '0;
      ge2      <= 1'b0;
      diff2    <= '0;
    end else begin
      if (adv1) begin
        if (|GNT) begin
          vld_pipe[1] <= 1'b1;
          id1         <= gnt_idx;
          a1          <= a_v[gnt_idx];
          b1          <= b_v[gnt_idx];
          last_q      <= gnt_idx;
        end else begin
          vld_pipe[1] <= 1'b0;
        end
      end
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        id2         <= id1;
        ge2         <= sum[W];
        diff2       <= sum[W-1:0];
      end
    end
  end

  assign RSP_VALID = vld_pipe[2];
  assign RSP_ID    = id2;
  assign RSP_GE    = ge2;
  assign RSP_DIFF  = diff2;
endmodule

// File: tb/tb_uge_share_arbiter.sv
// Scoreboard bench for uge_share_arbiter: driver predicts grants from a
// round-robin reference and queues expected responses; an independent
// monitor pops and compares whenever a response is handed over.
module tb_uge_share_arbiter;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = 2;

  logic           CLK;
  logic           RESETN;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] REQ_A, REQ_B;
  logic [N-1:0]   GNT;
  logic           RSP_VALID, RSP_READY;
  logic [IDW-1:0] RSP_ID;
  logic           RSP_GE;
  logic [W-1:0]   RSP_DIFF;

  uge_share_arbiter #(.N(N), .W(W)) dut (
    .CLK(CLK), .RESETN(RESETN), .REQ(REQ), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .GNT(GNT), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_ID(RSP_ID), .RSP_GE(RSP_GE), .RSP_DIFF(RSP_DIFF)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct { int id; int ge; int diff; } rsp_t;
  rsp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: occupancy of issue/output stages and last winner.
  bit m_v1, m_v2;
  int m_last;

  logic [N*W-1:0] va, vb;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_v1 = 0;
    m_v2 = 0;
    m_last = N - 1;
    exp_q.delete();
  endtask

  task automatic step(input logic [N-1:0] req, input logic [N*W-1:0] a,
                      input logic [N*W-1:0] b, input logic rdy);
    int   pick, ai, bi;
    bit   a1ok, a2ok;
    rsp_t r;
    @(negedge CLK);
    REQ = req; REQ_A = a; REQ_B = b; RSP_READY = rdy;
    #1;
    a2ok = !m_v2 || rdy;
    a1ok = !m_v1 || a2ok;
    pick = (a1ok && RESETN) ? rr_pick(req, m_last) : -1;
    chk("gnt", int'(GNT), (pick >= 0) ? (1 << pick) : 0);
    if (pick >= 0) begin
      ai = int'(a[pick*W +: W]);
      bi = int'(b[pick*W +: W]);
      r.id = pick;
      r.ge = (ai >= bi) ? 1 : 0;
      r.diff = (ai - bi) & ((1 << W) - 1);
      exp_q.push_back(r);
    end
    #2;
    if (RESETN) begin
      if (a2ok) m_v2 = m_v1;
      if (a1ok) m_v1 = (pick >= 0);
      if (pick >= 0) m_last = pick;
    end
  endtask

  task automatic rnd_ops();
    va = {$urandom, $urandom};
    vb = {$urandom, $urandom};
  endtask

  task automatic reset_pulse();
    @(negedge CLK);
    RESETN = 1'b0;
    model_clear();
    #1;
    chk("rst_valid", int'(RSP_VALID), 0);
    chk("rst_gnt", int'(GNT), 0);
  endtask

  // Release with REQ low so the intervening edge accepts nothing.
  task automatic reset_release();
    @(negedge CLK);
    REQ = '0;
    RESETN = 1'b1;
  endtask

  // Monitor: response valid tracks the reference; handovers are popped in order.
  always begin : mon
    rsp_t r;
    @(negedge CLK);
    #2;
    chk("rsp_valid", int'(RSP_VALID), int'(m_v2));
    if (RSP_VALID && RSP_READY) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        r = exp_q.pop_front();
        chk("rsp_id", int'(RSP_ID), r.id);
        chk("rsp_ge", int'(RSP_GE), r.ge);
        chk("rsp_diff", int'(RSP_DIFF), r.diff);
      end
    end
  end

  initial begin
    RESETN = 1'b0; REQ = '0; REQ_A = '0; REQ_B = '0; RSP_READY = 1'b1;
    model_clear();

    // Reset held with all requesting: no grant, no response.
    rnd_ops(); step(4'hF, va, vb, 1'b1);
    rnd_ops(); step(4'hF, va, vb, 1'b1);
    reset_release();
    rnd_ops(); step(4'hF, va, vb, 1'b1);   // expects 4'b0001
    repeat (3) step(4'h0, va, vb, 1'b1);

    // Single requester, both arithmetic directions.
    rnd_ops(); va[2*W +: W] = 4'd9; vb[2*W +: W] = 4'd5;
    step(4'b0100, va, vb, 1'b1);
    repeat (2) step(4'h0, va, vb, 1'b1);
    rnd_ops(); va[2*W +: W] = 4'd3; vb[2*W +: W] = 4'd12;
    step(4'b0100, va, vb, 1'b1);
    repeat (2) step(4'h0, va, vb, 1'b1);

    // All requesting, free-flowing: rotating grants, back-to-back responses.
    rnd_ops();
    repeat (9) step(4'hF, va, vb, 1'b1);

    // Backpressure with full pipe, then release.
    repeat (3) step(4'hF, va, vb, 1'b0);
    repeat (3) begin rnd_ops(); step(4'hF, va, vb, 1'b1); end
    repeat (3) step(4'h0, va, vb, 1'b1);

    // Reset with both stages occupied discards them.
    rnd_ops();
    repeat (3) step(4'hF, va, vb, 1'b0);
    reset_pulse();
    step(4'hF, va, vb, 1'b1);
    reset_release();
    step(4'hF, va, vb, 1'b1);              // expects requester 0
    repeat (3) step(4'h0, va, vb, 1'b1);

    // Exhaustive operand sweep through requester 1.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        rnd_ops();
        va[W +: W] = W'(a);
        vb[W +: W] = W'(b);
        step(4'b0010, va, vb, 1'b1);
      end
    end
    repeat (3) step(4'h0, va, vb, 1'b1);

    // Random requests, operands and backpressure.
    for (int t = 0; t < 400; t++) begin
      rnd_ops();
      step(N'($urandom), va, vb, ($urandom_range(0, 3) != 0));
    end
    repeat (4) step(4'h0, va, vb, 1'b1);

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
